// File: rtl/fp_addsub_if.sv
// Handshake bundle for fp_addsub: operand channel (x, y, sub) and result channel (z, status).
interface fp_addsub_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] z;
    logic [1:0]   status;

    modport master (output in_valid, x, y, sub, out_ready,
                    input  in_ready, out_valid, z, status);
    modport slave  (input  in_valid, x, y, sub, out_ready,
                    output in_ready, out_valid, z, status);
endinterface

// File: rtl/fp_addsub.sv
// Multi-cycle IEEE-754 adder/subtractor, round-to-nearest-even, one operation in flight.
// Gradual underflow when FP_SUBNORMAL_EN is defined; flush-to-zero otherwise.
//   state  | meaning
//   IDLE   | in_ready high, waiting for an operation
//   UNPACK | operands latched, special values resolved
//   ALIGN  | order by magnitude, shift smaller significand with sticky
//   ADD    | magnitude add or subtract
//   NORM   | carry shift right or leading-zero shift left
//   ROUND  | nearest-even rounding, overflow/underflow encoding
//   DONE   | result held until out_ready
module fp_addsub #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic       clk,
    input  logic       rst,
    fp_addsub_if.slave bus
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int F   = MAN_W + 4;
    localparam int SAT = MAN_W + 3;
    localparam int RW  = MAN_W + 2;
    localparam int EW  = EXP_W + 1;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;
    state_t state;

    logic [W-1:0]     xa, ya;
    logic             sgn, eff_sub, flush;
    logic [EXP_W-1:0] exp_r;
    logic [F-1:0]     big_f, small_f, norm_f;
    logic [F:0]       sum_r;
    logic             in_ready_r, out_valid_r;
    logic [W-1:0]     z_r;
    logic [1:0]       status_r;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.z         = z_r;
    assign bus.status    = status_r;

    logic             sx, sy;
    logic [EXP_W-1:0] ex, ey;
    logic [MAN_W-1:0] fx, fy;
    logic             nan_x, nan_y, inf_x, inf_y, zero_x, zero_y, special;
    logic [W-1:0]     special_z;
    logic [1:0]       special_st;

    assign {sx, ex, fx} = xa;
    assign {sy, ey, fy} = ya;
    assign nan_x = (ex == EXP_MAX) && (fx != '0);
    assign nan_y = (ey == EXP_MAX) && (fy != '0);
    assign inf_x = (ex == EXP_MAX) && (fx == '0);
    assign inf_y = (ey == EXP_MAX) && (fy == '0);
`ifdef FP_SUBNORMAL_EN
    assign zero_x = (ex == '0) && (fx == '0);
    assign zero_y = (ey == '0) && (fy == '0);
`else
    assign zero_x = (ex == '0);
    assign zero_y = (ey == '0);
`endif
    assign special = nan_x | nan_y | inf_x | inf_y | zero_x | zero_y;

    always_comb begin
        special_z  = xa;
        special_st = 2'b00;
        if (nan_x || nan_y || (inf_x && inf_y && (sx != sy))) begin
            special_z  = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
            special_st = 2'b11;
        end else if (inf_x)            special_z = xa;
        else if (inf_y)                special_z = ya;
        else if (zero_x && zero_y)     special_z = {sx & sy, {(W-1){1'b0}}};
        else if (zero_x)               special_z = ya;
    end

    // Raw-bit comparison of |x| and |y| matches IEEE magnitude ordering.
    logic             x_big;
    logic [EXP_W-1:0] eex, eey, e_big, e_small, diff;
    logic [F-1:0]     fx_f, fy_f, b_f, s_f, mask, aligned;
    int               sh_a;

    assign eex  = (ex == '0) ? EXP_W'(1) : ex;
    assign eey  = (ey == '0) ? EXP_W'(1) : ey;
    assign fx_f = {(ex != '0), fx, 3'b000};
    assign fy_f = {(ey != '0), fy, 3'b000};

    always_comb begin
        x_big   = (xa[W-2:0] >= ya[W-2:0]);
        b_f     = x_big ? fx_f : fy_f;
        s_f     = x_big ? fy_f : fx_f;
        e_big   = x_big ? eex : eey;
        e_small = x_big ? eey : eex;
        diff    = e_big - e_small;
        sh_a    = (int'(diff) > SAT) ? SAT : int'(diff);
        mask    = ~({F{1'b1}} << sh_a);
        aligned = (s_f >> sh_a) | F'(|(s_f & mask));
    end

    logic [F:0] sum_c;
    assign sum_c = eff_sub ? ({1'b0, big_f} - {1'b0, small_f})
                           : ({1'b0, big_f} + {1'b0, small_f});

    function automatic int lzc(input logic [F-1:0] v);
        int n;
        n = F;
        for (int i = 0; i < F; i++) if (v[i]) n = F - 1 - i;
        return n;
    endfunction

    int               lz, sh_n;
    logic [F-1:0]     norm_c;
    logic [EXP_W-1:0] exp_nc;
    logic             flush_c;

    always_comb begin
        lz      = lzc(sum_r[F-1:0]);
        flush_c = 1'b0;
        sh_n    = 0;
        if (sum_r[F]) begin
            norm_c = {sum_r[F:2], sum_r[1] | sum_r[0]};
            exp_nc = exp_r + EXP_W'(1);
        end else begin
`ifdef FP_SUBNORMAL_EN
            // Stop at the minimum exponent; whatever is left unnormalised is subnormal.
            sh_n = (lz < int'(exp_r) - 1) ? lz : int'(exp_r) - 1;
`else
            sh_n    = lz;
            flush_c = (int'(exp_r) - lz) < 1;
`endif
            norm_c = sum_r[F-1:0] << sh_n;
            exp_nc = exp_r - EXP_W'(sh_n);
        end
    end

    logic          inc;
    logic [RW-1:0] rnd;
    logic [EW-1:0] exp_f;
    logic [MAN_W-1:0] frac_f;
    logic [W-1:0]  round_z;
    logic [1:0]    round_st;

    always_comb begin
        inc = norm_f[2] & (norm_f[1] | norm_f[0] | norm_f[3]);
        rnd = {1'b0, norm_f[F-1:3]} + RW'(inc);
        if (rnd[RW-1]) begin
            exp_f  = {1'b0, exp_r} + EW'(1);
            frac_f = rnd[MAN_W:1];
        end else begin
            exp_f  = rnd[MAN_W] ? {1'b0, exp_r} : '0;
            frac_f = rnd[MAN_W-1:0];
        end
        if (flush) begin
            round_z  = {sgn, {(W-1){1'b0}}};
            round_st = 2'b10;
        end else if (exp_f >= {1'b0, EXP_MAX}) begin
            round_z  = {sgn, EXP_MAX, {MAN_W{1'b0}}};
            round_st = 2'b01;
        end else begin
            round_z  = {sgn, exp_f[EXP_W-1:0], frac_f};
            round_st = (exp_f == '0) ? 2'b10 : 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            z_r         <= '0;
            status_r    <= 2'b00;
            xa          <= '0;
            ya          <= '0;
            sgn         <= 1'b0;
            eff_sub     <= 1'b0;
            flush       <= 1'b0;
            exp_r       <= '0;
            big_f       <= '0;
            small_f     <= '0;
            norm_f      <= '0;
            sum_r       <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    xa         <= bus.x;
                    ya         <= {bus.y[W-1] ^ bus.sub, bus.y[W-2:0]};
                    in_ready_r <= 1'b0;
                    state      <= UNPACK;
                end
                UNPACK: if (special) begin
                    z_r         <= special_z;
                    status_r    <= special_st;
                    out_valid_r <= 1'b1;
                    state       <= DONE;
                end else begin
                    state <= ALIGN;
                end
                ALIGN: begin
                    sgn     <= x_big ? sx : sy;
                    eff_sub <= sx ^ sy;
                    exp_r   <= e_big;
                    big_f   <= b_f;
                    small_f <= aligned;
                    state   <= ADD;
                end
                ADD: if (eff_sub && (sum_c == '0)) begin
                    z_r         <= '0;
                    status_r    <= 2'b00;
                    out_valid_r <= 1'b1;
                    state       <= DONE;
                end else begin
                    sum_r <= sum_c;
                    state <= NORM;
                end
                NORM: begin
                    norm_f <= norm_c;
                    exp_r  <= exp_nc;
                    flush  <= flush_c;
                    state  <= ROUND;
                end
                ROUND: begin
                    z_r         <= round_z;
                    status_r    <= round_st;
                    out_valid_r <= 1'b1;
                    state       <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_addsub.sv
// Scoreboard bench for fp_addsub in single precision: expected results queued at drive time.
module tb_fp_addsub;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    typedef struct {
        logic [31:0] z;
        logic [1:0]  st;
        int          lat;
    } exp_t;
    exp_t sb[$];

    fp_addsub_if bus ();
    fp_addsub dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] ez, input logic [1:0] est,
                          input int elat, input int hold);
        exp_t e;
        int   edges;
        sb.push_back('{ez, est, elat});
        @(negedge clk);
        bus.x = a; bus.y = b; bus.sub = s; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        check_eq({tag, "_ready_before"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        // Scramble operands after accept: the DUT must not resample them.
        bus.in_valid = 1'b0; bus.x = '1; bus.y = '1; bus.sub = ~s;
        check_eq({tag, "_ready_busy"}, 32'(bus.in_ready), 32'd0);
        edges = 1;
        while (!bus.out_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        e = sb.pop_front();
        check_eq({tag, "_latency"}, 32'(edges), 32'(e.lat));
        check_eq({tag, "_z"}, bus.z, e.z);
        check_eq({tag, "_status"}, 32'(bus.status), 32'(e.st));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check_eq({tag, "_hold_z"}, bus.z, e.z);
            check_eq({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk); bus.out_ready = 1'b1;
        @(posedge clk); #1; bus.out_ready = 1'b0;
        check_eq({tag, "_consumed"}, 32'(bus.out_valid), 32'd0);
        check_eq({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int saw;
        bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.sub = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("reset_z", bus.z, 32'd0);
        check_eq("reset_status", 32'(bus.status), 32'd0);
        rst = 1'b1;

        run_op("basic_add",   32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 2'b00, 6, 0);
        run_op("cancel",      32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 2'b00, 4, 0);
        run_op("tie_even",    32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 2'b00, 6, 0);
        run_op("tie_odd",     32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 2'b00, 6, 0);
        run_op("overflow",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 2'b01, 6, 0);
        run_op("invalid",     32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 2'b11, 2, 0);
        run_op("nan_in",      32'h7FC12345, 32'h3F800000, 1'b0, 32'h7FC00000, 2'b11, 2, 0);
        run_op("inf_sub",     32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 2'b00, 2, 0);
        run_op("neg_zeros",   32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 2'b00, 2, 0);
        run_op("mixed_zeros", 32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 2'b00, 2, 0);
        run_op("zero_pass",   32'h00000000, 32'h40490FDB, 1'b0, 32'h40490FDB, 2'b00, 2, 0);
        run_op("sub_pos",     32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 2'b00, 6, 0);
        run_op("sub_neg",     32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 2'b00, 6, 0);
        run_op("carry",       32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 2'b00, 6, 0);
        run_op("near_cancel", 32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 2'b00, 6, 0);
`ifdef FP_SUBNORMAL_EN
        run_op("subnormal",   32'h00800000, 32'h00400000, 1'b1, 32'h00400000, 2'b10, 6, 0);
`else
        run_op("subnormal",   32'h00800000, 32'h00400000, 1'b1, 32'h00800000, 2'b00, 2, 0);
`endif
        run_op("backpress",   32'h40A00000, 32'h3F800000, 1'b0, 32'h40C00000, 2'b00, 6, 3);

        @(negedge clk);
        bus.x = 32'h3F800000; bus.y = 32'h40000000; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_eq("abort_busy", 32'(bus.in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        check_eq("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("abort_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk); rst = 1'b1;
        saw = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.out_valid) saw = 1;
        end
        check_eq("abort_no_result", 32'(saw), 32'd0);
        check_eq("abort_ready_after", 32'(bus.in_ready), 32'd1);

        run_op("after_abort", 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 2'b00, 6, 0);
        check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
